// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default baud divisor.
// Also intended for the companion receiver.
package uart_pkg;

   localparam int UART_DATA_W          = 8;
   localparam int UART_DEFAULT_CLK_DIV = 434;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   // Even parity of the byte, inverted when odd parity is selected.
   function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: runs 0..CLK_DIV-1 and flags the final cycle of every bit period.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLK_DIV = UART_DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   assign bit_end = (r_cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear || bit_end) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer fed by a byte FIFO: start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits; drains the FIFO back-to-back.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = UART_DEFAULT_CLK_DIV,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tx_en,
   input  logic                   fifo_empty,
   input  logic [UART_DATA_W-1:0] fifo_rddata,
   output logic                   fifo_rd,
   output logic                   tx,
   output logic                   busy,
   output logic                   tx_done
);

   localparam int               IDX_W     = $clog2(UART_DATA_W);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(UART_DATA_W - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
   localparam logic             PAR_ON    = (PARITY_EN != 0);
   localparam logic             PAR_ODD   = (PARITY_ODD != 0);

   uart_state_t            r_state;
   logic [UART_DATA_W-1:0] r_shift;
   logic [IDX_W-1:0]       r_bit_idx;
   logic                   r_parity;
   logic                   r_tx;
   logic                   w_bit_end;
   logic                   w_baud_clear;
   logic                   w_pop;

   // The pop must land in the IDLE cycle so the FIFO data is valid during FETCH;
   // holding reset suppresses it so nothing is consumed while the block is reset.
   assign w_pop        = (r_state == IDLE) && tx_en && !fifo_empty && !rst;
   assign w_baud_clear = (r_state == IDLE) || (r_state == FETCH);

   assign fifo_rd = w_pop;
   assign tx      = r_tx;
   assign busy    = (r_state != IDLE);
   assign tx_done = (r_state == STOP) && w_bit_end && (r_bit_idx == LAST_STOP);

   uart_baud_cnt #(
      .CLK_DIV (CLK_DIV)
   ) u_baud_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_baud_clear),
      .bit_end (w_bit_end)
   );

   // r_tx is updated on the same edge as the state, so the line tracks the state exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_tx      <= 1'b1;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_parity  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx      <= 1'b1;
               r_bit_idx <= '0;
               if (w_pop) begin
                  r_state <= FETCH;
               end
            end
            FETCH: begin
               r_shift  <= fifo_rddata;
               r_parity <= uart_parity(fifo_rddata, PAR_ODD);
               r_tx     <= 1'b0;
               r_state  <= START;
            end
            START: begin
               if (w_bit_end) begin
                  r_tx      <= r_shift[0];
                  r_shift   <= r_shift >> 1;
                  r_bit_idx <= '0;
                  r_state   <= DATA;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  if (r_bit_idx == LAST_DATA) begin
                     r_bit_idx <= '0;
                     if (PAR_ON) begin
                        r_tx    <= r_parity;
                        r_state <= PARITY;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_tx      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                  end
               end
            end
            PARITY: begin
               if (w_bit_end) begin
                  r_tx      <= 1'b1;
                  r_bit_idx <= '0;
                  r_state   <= STOP;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  if (r_bit_idx == LAST_STOP) begin
                     r_bit_idx <= '0;
                     r_state   <= IDLE;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parity/stop-bit variants share one FIFO model,
// and only the selected variant ever sees a non-empty FIFO.
module tb_uart_tx;

   localparam int CD = 4;

   logic       clk         = 1'b0;
   logic       rst         = 1'b1;
   logic       tx_en       = 1'b0;
   logic [1:0] sel         = 2'd0;
   logic [7:0] fifo_rddata = 8'h00;
   logic       fifo_empty;
   logic       fifo_rd;
   logic       tx;
   logic       busy;
   logic       tx_done;
   logic [3:0] empty_v;
   logic [3:0] rd_v;
   logic [3:0] tx_v;
   logic [3:0] busy_v;
   logic [3:0] done_v;
   logic [7:0] mem [0:255];
   int         wr_ptr     = 0;
   int         rd_ptr     = 0;
   int         cyc        = 0;
   int         rd_illegal = 0;
   int         n_checks   = 0;
   int         n_errors   = 0;

   always #5 clk = ~clk;

   // Variants: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 8N2.
   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      assign empty_v[gi] = (sel == 2'(gi)) ? fifo_empty : 1'b1;
      uart_tx #(
         .CLK_DIV    (CD),
         .STOP_BITS  ((gi == 3) ? 2 : 1),
         .PARITY_EN  ((gi == 1 || gi == 2) ? 1 : 0),
         .PARITY_ODD ((gi == 2) ? 1 : 0)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .tx_en       (tx_en),
         .fifo_empty  (empty_v[gi]),
         .fifo_rddata (fifo_rddata),
         .fifo_rd     (rd_v[gi]),
         .tx          (tx_v[gi]),
         .busy        (busy_v[gi]),
         .tx_done     (done_v[gi])
      );
   end

   assign fifo_empty = (rd_ptr >= wr_ptr);
   assign fifo_rd    = rd_v[sel];
   assign tx         = tx_v[sel];
   assign busy       = busy_v[sel];
   assign tx_done    = done_v[sel];

   // FIFO model: read data appears the cycle after the pop strobe.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd === 1'b1) begin
         if (rd_ptr < 256) fifo_rddata <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 1;
      end
   end

   always @(negedge clk) begin
      if (fifo_rd === 1'b1 && (fifo_empty || busy)) rd_illegal <= rd_illegal + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr++;
   endtask

   task automatic wait_tx_low(output bit ok);
      int w = 0;
      @(negedge clk);
      while (tx !== 1'b0 && w < 4000) begin
         @(negedge clk);
         w++;
      end
      ok = (tx === 1'b0);
   endtask

   // Samples one frame cycle by cycle from its first low cycle; shape_err counts
   // bits not held steadily, a high start bit, or low stop bits.
   task automatic recv_frame(input int pe, input int sb, output logic [7:0] d, output logic p,
                             output int t0, output int shape_err, output int done_at);
      logic s [0:63];
      bit   ok;
      int   nbits;
      nbits     = 9 + pe + sb;
      d         = '0;
      p         = 1'b0;
      t0        = -1;
      shape_err = 0;
      done_at   = -1;
      wait_tx_low(ok);
      if (!ok) begin
         shape_err = 999;
      end else begin
         t0 = cyc;
         for (int c = 0; c < nbits * CD; c++) begin
            if (c != 0) @(negedge clk);
            s[c] = tx;
            if (tx_done === 1'b1) begin
               if (done_at < 0) done_at = c;
               else shape_err++;
            end
         end
         for (int b = 0; b < nbits; b++)
            for (int k = 1; k < CD; k++)
               if (s[b*CD+k] !== s[b*CD]) shape_err++;
         if (s[0] !== 1'b0) shape_err++;
         for (int b = 9 + pe; b < nbits; b++)
            if (s[b*CD] !== 1'b1) shape_err++;
         for (int i = 0; i < 8; i++) d[i] = s[(i+1)*CD];
         p = s[9*CD];
      end
   endtask

   task automatic frame_checks(input string tag, input logic [7:0] d, input logic [7:0] exp,
                               input int serr, input int dat, input int dat_exp);
      $display("%s: frame data=0x%02h shape_err=%0d done_at=%0d", tag, d, serr, dat);
      check_eq({tag, "_data"}, d, exp);
      check_eq({tag, "_shape"}, serr, 0);
      check_eq({tag, "_done_at"}, dat, dat_exp);
   endtask

   logic [7:0] d;
   logic       p;
   int         t0;
   int         t_prev;
   int         serr;
   int         dat;
   int         base;
   int         bad;
   bit         ok;

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_tx", tx, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rd", fifo_rd, 0);
      check_eq("rst_done", tx_done, 0);

      rst   = 1'b0;
      tx_en = 1'b1;
      bad   = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0) bad++;
      end
      check_eq("idle_quiet", bad, 0);

      // Single byte: 0x55 gives alternating 0,1,... line levels.
      base = rd_ptr;
      push(8'h55);
      recv_frame(0, 1, d, p, t0, serr, dat);
      frame_checks("b55", d, 8'h55, serr, dat, 39);
      repeat (3) @(negedge clk);
      check_eq("b55_pops", rd_ptr - base, 1);
      check_eq("b55_busy", busy, 0);

      // 32-byte burst: back-to-back frames with a 6-cycle high gap.
      base = rd_ptr;
      for (int i = 0; i < 32; i++) push(8'(i));
      t_prev = 0;
      for (int i = 0; i < 32; i++) begin
         recv_frame(0, 1, d, p, t0, serr, dat);
         frame_checks("burst", d, 8'(i), serr, dat, 39);
         if (i > 0) check_eq("burst_gap", t0 - t_prev - 9 * CD, 6);
         t_prev = t0;
      end
      repeat (4) @(negedge clk);
      check_eq("burst_pops", rd_ptr - base, 32);
      check_eq("burst_empty", fifo_empty, 1);
      check_eq("burst_busy", busy, 0);

      // Parity: 0x07 has three ones -> even parity 1, odd parity 0.
      sel = 2'd1;
      push(8'h07);
      recv_frame(1, 1, d, p, t0, serr, dat);
      frame_checks("par_even", d, 8'h07, serr, dat, 43);
      check_eq("par_even_bit", p, 1);
      repeat (4) @(negedge clk);
      sel = 2'd2;
      push(8'h07);
      recv_frame(1, 1, d, p, t0, serr, dat);
      frame_checks("par_odd", d, 8'h07, serr, dat, 43);
      check_eq("par_odd_bit", p, 0);
      repeat (4) @(negedge clk);

      // Two stop bits: 44-cycle frames, 10-cycle high gap.
      sel = 2'd3;
      push(8'hA5);
      push(8'h3C);
      recv_frame(0, 2, d, p, t0, serr, dat);
      frame_checks("stop2_a", d, 8'hA5, serr, dat, 43);
      t_prev = t0;
      recv_frame(0, 2, d, p, t0, serr, dat);
      frame_checks("stop2_b", d, 8'h3C, serr, dat, 43);
      check_eq("stop2_gap", t0 - t_prev - 9 * CD, 10);
      repeat (4) @(negedge clk);

      // tx_en dropped during D3: frame finishes, no further pop.
      sel  = 2'd0;
      base = rd_ptr;
      push(8'h81);
      push(8'h42);
      push(8'h99);
      fork
         recv_frame(0, 1, d, p, t0, serr, dat);
         begin
            bit lo;
            wait_tx_low(lo);
            repeat (17) @(negedge clk);
            tx_en = 1'b0;
         end
      join
      frame_checks("en_drop", d, 8'h81, serr, dat, 39);
      repeat (60) @(negedge clk);
      check_eq("en_drop_pops", rd_ptr - base, 1);
      check_eq("en_drop_busy", busy, 0);
      check_eq("en_drop_tx", tx, 1);

      // Reset during D5 of 0x42 (a low bit), then 0x99 follows.
      tx_en = 1'b1;
      wait_tx_low(ok);
      check_eq("rst_frame_start", ok, 1);
      repeat (25) @(negedge clk);
      check_eq("rst_d5_low", tx, 0);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_tx", tx, 1);
      check_eq("rst_mid_busy", busy, 0);
      repeat (5) @(negedge clk);
      check_eq("rst_mid_pops", rd_ptr - base, 2);
      rst = 1'b0;
      recv_frame(0, 1, d, p, t0, serr, dat);
      frame_checks("after_rst", d, 8'h99, serr, dat, 39);
      repeat (4) @(negedge clk);
      check_eq("after_rst_pops", rd_ptr - base, 3);
      check_eq("rd_illegal", rd_illegal, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
